// File: rtl/mem_ctrl.sv
// mem_ctrl: memory access controller for the d16 core.
//
// Launches one bus access per FETCH or MEM control state. It holds the
// request until the bus acknowledges or the timeout expires. It then parks in
// DONE until control leaves the access state.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   en                 core enable, gates only the launch of a new access
//   control_i          one-hot control state; STATE_FETCH / STATE_MEM decoded
//   pc_i               fetch byte address
//   data_addr_i        load/store byte address
//   data_wdata_i       store data
//   data_we_i          1 = store, 0 = load
//   data_byte_i        1 = byte access, 0 = word access
//   mem_wait_o         combinational stall back to control
//   instr_o            last fetched instruction word
//   rdata_o            last load result
//   fault_o            one-cycle pulse when an access times out
//   bus_req_o          bus request, held until ack or abort
//   bus_we_o           bus write strobe
//   bus_addr_o         bus word address (byte address [15:1])
//   bus_be_o           byte enables, bit0 = low byte / even address
//   bus_wdata_o        bus write data
//   bus_ack_i          access complete, bus_rdata_i valid in the same cycle
//   bus_rdata_i        bus read data
module mem_ctrl #(
    parameter int unsigned TIMEOUT         = 255,
    parameter int unsigned CONTROL_BIT_MAX = 7,
    parameter int unsigned STATE_FETCH     = 0,
    parameter int unsigned STATE_MEM       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [CONTROL_BIT_MAX:0] control_i,
    input  logic [15:0]              pc_i,
    input  logic [15:0]              data_addr_i,
    input  logic [15:0]              data_wdata_i,
    input  logic                     data_we_i,
    input  logic                     data_byte_i,
    output logic                     mem_wait_o,
    output logic [15:0]              instr_o,
    output logic [15:0]              rdata_o,
    output logic                     fault_o,
    output logic                     bus_req_o,
    output logic                     bus_we_o,
    output logic [14:0]              bus_addr_o,
    output logic [1:0]               bus_be_o,
    output logic [15:0]              bus_wdata_o,
    input  logic                     bus_ack_i,
    input  logic [15:0]              bus_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]  state_q,       state_d;
    logic        bus_req_q,     bus_req_d;
    logic        bus_we_q,      bus_we_d;
    logic [14:0] bus_addr_q,    bus_addr_d;
    logic [1:0]  bus_be_q,      bus_be_d;
    logic [15:0] bus_wdata_q,   bus_wdata_d;
    logic [15:0] instr_q,       instr_d;
    logic [15:0] rdata_q,       rdata_d;
    logic        fault_q,       fault_d;
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;
    logic        is_fetch_q,    is_fetch_d;
    logic        is_byte_q,     is_byte_d;

    logic        ctl_fetch;
    logic        ctl_mem;
    logic        ctl_access;
    logic [7:0]  cnt_inc;
    logic [7:0]  sel_byte;
    logic        unused_inputs;

    assign ctl_fetch  = control_i[STATE_FETCH];
    assign ctl_mem    = control_i[STATE_MEM];
    assign ctl_access = ctl_fetch | ctl_mem;
    assign cnt_inc    = timeout_cnt_q + 8'd1;

    // The enabled lane of a byte access also selects which half of the read
    // word is returned.
    assign sel_byte   = bus_be_q[1] ? bus_rdata_i[15:8] : bus_rdata_i[7:0];

    // Only the two access bits of control_i are decoded, and fetches are
    // always word aligned.
    assign unused_inputs = ^{control_i, pc_i[0]};

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        instr_d       = instr_q;
        rdata_d       = rdata_q;
        fault_d       = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        is_fetch_d    = is_fetch_q;
        is_byte_d     = is_byte_q;

        case (state_q)
            ST_IDLE: begin
                if (en && ctl_access) begin
                    state_d   = ST_BUSY;
                    bus_req_d = 1'b1;
                    if (ctl_fetch) begin
                        is_fetch_d  = 1'b1;
                        is_byte_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = pc_i[15:1];
                        bus_be_d    = 2'b11;
                        bus_wdata_d = 16'h0000;
                    end else begin
                        is_fetch_d = 1'b0;
                        is_byte_d  = data_byte_i;
                        bus_we_d   = data_we_i;
                        // Word accesses ignore address bit 0 (aligned down).
                        bus_addr_d = data_addr_i[15:1];
                        if (data_byte_i) begin
                            bus_be_d    = data_addr_i[0] ? 2'b10 : 2'b01;
                            bus_wdata_d = {data_wdata_i[7:0], data_wdata_i[7:0]};
                        end else begin
                            bus_be_d    = 2'b11;
                            bus_wdata_d = data_wdata_i;
                        end
                    end
                end
            end

            ST_BUSY: begin
                // An ack in the last allowed cycle wins over the timeout.
                if (bus_ack_i) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (is_fetch_q) begin
                        instr_d = bus_rdata_i;
                    end else if (!bus_we_q) begin
                        rdata_d = is_byte_q ? {8'h00, sel_byte} : bus_rdata_i;
                    end
                end else begin
                    timeout_cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        state_d   = ST_DONE;
                        bus_req_d = 1'b0;
                        fault_d   = 1'b1;
                        if (is_fetch_q) begin
                            instr_d = 16'hFFFF;
                        end else begin
                            rdata_d = 16'hFFFF;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (!ctl_access) begin
                    state_d       = ST_IDLE;
                    timeout_cnt_d = 8'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 15'h0000;
            bus_be_q      <= 2'b00;
            bus_wdata_q   <= 16'h0000;
            instr_q       <= 16'h0000;
            rdata_q       <= 16'h0000;
            fault_q       <= 1'b0;
            timeout_cnt_q <= 8'd0;
            is_fetch_q    <= 1'b0;
            is_byte_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            instr_q       <= instr_d;
            rdata_q       <= rdata_d;
            fault_q       <= fault_d;
            timeout_cnt_q <= timeout_cnt_d;
            is_fetch_q    <= is_fetch_d;
            is_byte_q     <= is_byte_d;
        end
    end

    // The stall is decoded straight from control so that the access state
    // needs no bubble on entry.
    assign mem_wait_o  = ctl_access && (state_q != ST_DONE);
    assign instr_o     = instr_q;
    assign rdata_o     = rdata_q;
    assign fault_o     = fault_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl.
//
// Each access is described as a transaction with the following fields:
//   kind, byte flag, address, data, ack latency, enable delay, DONE hold.
// The expected waveform of every output is derived from timeline arithmetic
// on those fields:
//   launch at the end of cycle d, ack or abort in cycle E, DONE in cycle E+1.
module tb_mem_ctrl;

    localparam int TIMEOUT  = 4;
    localparam int CBM      = 7;
    localparam int ST_FETCH = 1;
    localparam int ST_MEM   = 4;

    logic           clk;
    logic           rst;
    logic           en;
    logic [CBM:0]   control_i;
    logic [15:0]    pc_i;
    logic [15:0]    data_addr_i;
    logic [15:0]    data_wdata_i;
    logic           data_we_i;
    logic           data_byte_i;
    logic           mem_wait_o;
    logic [15:0]    instr_o;
    logic [15:0]    rdata_o;
    logic           fault_o;
    logic           bus_req_o;
    logic           bus_we_o;
    logic [14:0]    bus_addr_o;
    logic [1:0]     bus_be_o;
    logic [15:0]    bus_wdata_o;
    logic           bus_ack_i;
    logic [15:0]    bus_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_instr;
    logic [15:0] exp_rdata;

    mem_ctrl #(
        .TIMEOUT         (TIMEOUT),
        .CONTROL_BIT_MAX (CBM),
        .STATE_FETCH     (ST_FETCH),
        .STATE_MEM       (ST_MEM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .control_i    (control_i),
        .pc_i         (pc_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_we_i    (data_we_i),
        .data_byte_i  (data_byte_i),
        .mem_wait_o   (mem_wait_o),
        .instr_o      (instr_o),
        .rdata_o      (rdata_o),
        .fault_o      (fault_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CBM:0] idle_ctrl();
        int p;
        logic [CBM:0] v;
        do p = int'($urandom_range(0, CBM)); while (p == ST_FETCH || p == ST_MEM);
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [CBM:0] onehot(input int b);
        logic [CBM:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // kind: 0 fetch, 1 load, 2 store. lat: BUSY cycle carrying the ack
    // (lat > TIMEOUT means the access times out first). d: cycles with en
    // low after control enters the access state. x: extra DONE cycles.
    task automatic run_txn(input int kind, input bit bytem, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int lat, input int d, input int x);
        bit          to;
        int          e_end;
        int          total;
        bit          in_acc;
        logic [14:0] e_addr;
        logic [1:0]  e_be;
        logic        e_we;
        logic [15:0] e_wd;
        logic [7:0]  hi;
        logic [7:0]  lo;

        to     = (lat > TIMEOUT);
        e_end  = to ? d + TIMEOUT : d + lat;
        total  = e_end + 2 + x;
        e_addr = addr[15:1];
        lo     = wd[7:0];
        if (kind == 0) begin
            e_be = 2'b11;
            e_we = 1'b0;
            e_wd = 16'h0000;
        end else begin
            e_we = (kind == 2);
            if (bytem) begin
                e_be = addr[0] ? 2'b10 : 2'b01;
                e_wd = {lo, lo};
            end else begin
                e_be = 2'b11;
                e_wd = wd;
            end
        end

        for (int c = 0; c < total + 2; c++) begin
            in_acc = (c < total);
            control_i = in_acc ? ((kind == 0) ? onehot(ST_FETCH) : onehot(ST_MEM)) : idle_ctrl();
            en = in_acc ? (c >= d) : 1'($urandom);
            if (c <= d) begin
                pc_i         = (kind == 0) ? addr : 16'($urandom);
                data_addr_i  = (kind != 0) ? addr : 16'($urandom);
                data_wdata_i = wd;
                data_we_i    = (kind == 2);
                data_byte_i  = bytem;
            end else begin
                // Inputs may wander once the access is launched.
                pc_i         = 16'($urandom);
                data_addr_i  = 16'($urandom);
                data_wdata_i = 16'($urandom);
                data_we_i    = 1'($urandom);
                data_byte_i  = 1'($urandom);
            end
            if (c == d + lat) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rd;
            end else begin
                bus_ack_i   = (c <= d || c > e_end) ? 1'($urandom) : 1'b0;
                bus_rdata_i = 16'($urandom);
            end

            @(negedge clk);
            if (c == e_end + 1) begin
                hi = rd[15:8];
                lo = rd[7:0];
                if (kind == 0) begin
                    exp_instr = to ? 16'hFFFF : rd;
                end else if (to) begin
                    exp_rdata = 16'hFFFF;
                end else if (kind == 1) begin
                    exp_rdata = bytem ? {8'h00, (addr[0] ? hi : lo)} : rd;
                end
            end
            chk("mem_wait", 32'(mem_wait_o), 32'(in_acc && c <= e_end));
            chk("bus_req", 32'(bus_req_o), 32'(c >= d + 1 && c <= e_end));
            chk("fault", 32'(fault_o), 32'(to && c == e_end + 1));
            chk("instr", 32'(instr_o), 32'(exp_instr));
            chk("rdata", 32'(rdata_o), 32'(exp_rdata));
            if (c >= d + 1) begin
                chk("bus_addr", 32'(bus_addr_o), 32'(e_addr));
                chk("bus_be", 32'(bus_be_o), 32'(e_be));
                chk("bus_we", 32'(bus_we_o), 32'(e_we));
                if (kind != 0) chk("bus_wdata", 32'(bus_wdata_o), 32'(e_wd));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        control_i    = '0;
        pc_i         = 16'h0000;
        data_addr_i  = 16'h0000;
        data_wdata_i = 16'h0000;
        data_we_i    = 1'b0;
        data_byte_i  = 1'b0;
        bus_ack_i    = 1'b0;
        bus_rdata_i  = 16'h0000;
        exp_instr    = 16'h0000;
        exp_rdata    = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_addr", 32'(bus_addr_o), 32'd0);
        chk("rst_be", 32'(bus_be_o), 32'd0);
        chk("rst_wdata", 32'(bus_wdata_o), 32'd0);
        chk("rst_instr", 32'(instr_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_wait", 32'(mem_wait_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-wait fetch.
        run_txn(0, 1'b0, 16'h0102, 16'h0000, 16'hBEEF, 1, 0, 0);
        chk("fetch_instr", 32'(instr_o), 32'h0000BEEF);
        chk("fetch_addr", 32'(bus_addr_o), 32'h00000081);
        // Odd-byte load after waits.
        run_txn(1, 1'b1, 16'h0011, 16'h0000, 16'hA55A, 3, 0, 1);
        chk("bload_rdata", 32'(rdata_o), 32'h000000A5);
        chk("bload_be", 32'(bus_be_o), 32'h2);
        // Even-byte store with replicated write data.
        run_txn(2, 1'b1, 16'h0010, 16'h1234, 16'h9999, 2, 0, 0);
        chk("bstore_wdata", 32'(bus_wdata_o), 32'h00003434);
        chk("bstore_be", 32'(bus_be_o), 32'h1);
        chk("bstore_rdata", 32'(rdata_o), 32'h000000A5);
        // Fetch timeout.
        run_txn(0, 1'b0, 16'h0400, 16'h0000, 16'h1111, TIMEOUT + 2, 0, 1);
        chk("to_instr", 32'(instr_o), 32'h0000FFFF);
        // Enable held low for two cycles, ack on the last allowed cycle.
        run_txn(0, 1'b0, 16'h2222, 16'h0000, 16'h5A5A, TIMEOUT, 2, 0);
        // Word load on an odd address aligns down.
        run_txn(1, 1'b0, 16'h1235, 16'h0000, 16'hC0DE, 2, 1, 2);

        // Reset in the middle of a fetch, followed by a stray ack.
        control_i = onehot(ST_FETCH);
        en        = 1'b1;
        pc_i      = 16'h0200;
        bus_ack_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_req_before", 32'(bus_req_o), 32'd1);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        control_i   = idle_ctrl();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 16'h7777;
        @(negedge clk);
        chk("mid_req", 32'(bus_req_o), 32'd0);
        chk("mid_instr", 32'(instr_o), 32'd0);
        chk("mid_rdata", 32'(rdata_o), 32'd0);
        @(posedge clk);
        #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        chk("late_ack_instr", 32'(instr_o), 32'd0);
        chk("late_ack_req", 32'(bus_req_o), 32'd0);
        chk("late_ack_fault", 32'(fault_o), 32'd0);
        @(posedge clk);
        #1;
        exp_instr = 16'h0000;
        exp_rdata = 16'h0000;
        // The controller must be back in IDLE and launch normally.
        run_txn(0, 1'b0, 16'h0300, 16'h0000, 16'h4321, 1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            run_txn(int'($urandom_range(0, 2)), 1'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), int'($urandom_range(1, TIMEOUT + 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
